if_stage: RTL
=============

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline; producer of the IF/ID interface consumed by ID_Stage.
//  Holds the PC, reads a word-addressed instruction memory, registers {instruction, PC+4} into the IF/ID latch.
//  Honours hazard-unit stall and branch redirect/flush; memory is loadable at run time through a write port.
// PARAMETERS
//  IMEM_DEPTH  256           number of 32-bit instruction words (power of 2)
//  RESET_PC    32'h00000000  PC value after reset
// PORTS
//  clk            in   1   clock, all state updates on posedge
//  rst_n          in   1   synchronous reset, active low
//  stall          in   1   hazard unit: hold PC and IF/ID latch
//  branch_taken   in   1   redirect PC to branch_target, flush IF/ID
//  branch_target  in   32  redirect byte address
//  imem_we        in   1   instruction-memory write enable
//  imem_waddr     in   32  byte address of word to write
//  imem_wdata     in   32  word to write
//  pc             out  32  current fetch address
//  instruction    out  32  IF/ID latched instruction (to ID_Stage.instruction)
//  new_pc_value   out  32  IF/ID latched PC+4 (to ID_Stage.in_new_pc_value)
//  if_valid       out  1   IF/ID latch holds a real fetched instruction
// BEHAVIOUR
//  Clock/reset: one clock clk; reset is synchronous and active-low (rst_n).
//  Reset (rst_n=0 at posedge): pc=RESET_PC, instruction=NOP (32'h0), new_pc_value=0, if_valid=0. Memory contents are not cleared.
//  Fetch: word index = pc[log2(IMEM_DEPTH)+1:2]; combinational read; pc >= 4*IMEM_DEPTH reads NOP.
//  Latency: instruction at pc appears on instruction/new_pc_value one cycle after pc presents it.
//  Priority per posedge, highest first: rst_n=0 > branch_taken > stall > normal.
//   branch_taken: pc<=branch_target & ~32'h3; instruction<=NOP; new_pc_value<=0; if_valid<=0. Overrides stall.
//   stall (no branch): pc, instruction, new_pc_value, if_valid all hold.
//   normal: instruction<=imem[pc]; new_pc_value<=pc+4; if_valid<=1; pc<=pc+4.
//  Arithmetic: pc+4 is 32-bit modulo; 32'hFFFFFFFC wraps to 0 without flag.
//  pc[1:0] is always 0: the branch target is force-aligned, never faulted.
//  Memory write: on posedge with imem_we=1, imem[imem_waddr word index]<=imem_wdata.
//   Out-of-range imem_waddr is ignored. imem_waddr[1:0] is ignored.
//   Write independent of stall/branch; ignored while rst_n=0.
//   Same-cycle write and fetch of same word: latch captures OLD word (read-before-write).
//   Next fetch of that word returns new data.
//  Reset mid-operation: pending branch/stall discarded; first fetch after release is at RESET_PC.
// STRUCTURE
//  Shared package mips_pkg: MIPS_NOP=32'h0, WORD_W=32, PC_STEP=4, funct/opcode localparams shared with ID_Stage.
//  Sub-module instr_mem (IMEM_DEPTH): sync write port, async read port, out-of-range read returns NOP.
//  if_stage holds PC register, next-PC mux (branch/hold/+4), IF/ID latch.
// TESTING
//  1 Reset: hold rst_n=0 two cycles -> pc=0, instruction=0, new_pc_value=0, if_valid=0.
//  2 Load imem[0..2]={32'h00210800,32'h00421000,32'h00842000}, release reset.
//    Cycles 1..3: instruction = those words; new_pc_value=4,8,12; if_valid=1.
//  3 Stall for 2 cycles after first fetch -> instruction stays 32'h00210800, pc stays 4; resume -> 32'h00421000.
//  4 branch_taken=1, target=32'h0000000E, with stall=1 -> next cycle if_valid=0, instruction=0, pc=32'h0C.
//    Following cycle fetches imem[3].
//  5 imem_we to address 4 while pc=4 -> latch gets old word; after branch back to 4, new word is fetched.
//  6 pc beyond 4*IMEM_DEPTH -> instruction=0, if_valid=1. Assert rst_n=0 mid-stall -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: word width, NOP encoding, opcode/funct codes
// and the IF/ID latch payload.
package mips_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [WORD_W-1:0] MIPS_NOP = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] instruction;
    logic [WORD_W-1:0] new_pc_value;
  } if_id_t;

  // Byte address forced onto a word boundary.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return addr & ~WORD_W'(3);
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Word-addressed instruction memory: synchronous write port, combinational read port.
// Byte addresses outside the array read as NOP and are dropped on write.
module instr_mem
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [WORD_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [WORD_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata_c
);

  localparam int unsigned IDX_W = $clog2(IMEM_DEPTH);

  logic [WORD_W-1:0] mem [IMEM_DEPTH];

  logic [IDX_W-1:0] widx_c;
  logic [IDX_W-1:0] ridx_c;
  logic             w_in_range_c;
  logic             r_in_range_c;
  logic             unused_c;

  assign widx_c       = waddr[IDX_W+1:2];
  assign ridx_c       = raddr[IDX_W+1:2];
  assign w_in_range_c = (waddr[WORD_W-1:IDX_W+2] == '0);
  assign r_in_range_c = (raddr[WORD_W-1:IDX_W+2] == '0);

  // Byte offsets within a word carry no information for a word memory.
  assign unused_c = ^{waddr[1:0], raddr[1:0]};

  // Contents survive reset; only the write is gated by it.
  always_ff @(posedge clk) begin
    if (rst_n && we && w_in_range_c) begin
      mem[widx_c] <= wdata;
    end
  end

  assign rdata_c = r_in_range_c ? mem[ridx_c] : MIPS_NOP;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select (redirect / hold / +4),
// and the IF/ID latch feeding the decode stage.
module if_stage
  import mips_pkg::*;
#(
  parameter int unsigned       IMEM_DEPTH = 256,
  parameter logic [WORD_W-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              imem_we,
  input  logic [WORD_W-1:0] imem_waddr,
  input  logic [WORD_W-1:0] imem_wdata,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] instruction,
  output logic [WORD_W-1:0] new_pc_value,
  output logic              if_valid
);

  localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, instruction: MIPS_NOP, new_pc_value: '0};

  logic [WORD_W-1:0] fetch_c;
  logic [WORD_W-1:0] pc_plus4_c;
  logic [WORD_W-1:0] pc_next_c;
  if_id_t            if_id_q;
  if_id_t            if_id_next_c;

  instr_mem #(
    .IMEM_DEPTH(IMEM_DEPTH)
  ) u_instr_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (imem_we),
    .waddr  (imem_waddr),
    .wdata  (imem_wdata),
    .raddr  (pc),
    .rdata_c(fetch_c)
  );

  assign pc_plus4_c = pc + WORD_W'(PC_STEP);

  // Redirect beats stall; the latch captures the pre-write word on a same-cycle write.
  always_comb begin
    pc_next_c    = pc;
    if_id_next_c = if_id_q;
    if (branch_taken) begin
      pc_next_c    = align_word(branch_target);
      if_id_next_c = IF_ID_BUBBLE;
    end else if (!stall) begin
      pc_next_c    = pc_plus4_c;
      if_id_next_c = '{valid: 1'b1, instruction: fetch_c, new_pc_value: pc_plus4_c};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      if_id_q <= IF_ID_BUBBLE;
    end else begin
      pc      <= pc_next_c;
      if_id_q <= if_id_next_c;
    end
  end

  assign instruction  = if_id_q.instruction;
  assign new_pc_value = if_id_q.new_pc_value;
  assign if_valid     = if_id_q.valid;

endmodule
